// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - Default operand width
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor, purely combinational.
// Ports:
//   x    in   minuend bit
//   y    in   subtrahend bit
//   bin  in   borrow in from the less significant bit
//   d    out  difference bit
//   bout out  borrow out to the next bit
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x, or when x==y and a borrow is already pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first,
// one bit per clock using a single full_subtractor cell.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin an operation (only honoured while idle)
//   a, b       in   operands, captured when start is accepted
//   diff       out  registered result, held until the next completion
//   borrow_out out  registered final borrow (1 iff a < b)
//   busy       out  operation in progress (SHIFT or DONE)
//   done       out  one-cycle pulse when diff/borrow_out are updated
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // Holds the WIDTH-1 bits produced so far; the last bit comes straight
  // from the cell on the final cycle, so one bit of storage is saved.
  logic [WIDTH-2:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic             fs_d, fs_bout;
  logic [WIDTH-1:0] res_full;

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bor_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign res_full = {fs_d, res_q};

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    bor_d        = bor_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bor_d = fs_bout;
        res_d = res_full[WIDTH-1:1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_DONE;
          diff_d       = res_full;
          borrow_out_d = fs_bout;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bor_q        <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bor_q        <= bor_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  // Operand/result shift registers carry no control meaning; no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        borrow8, busy8, done8;
  logic        borrow16, busy16, done16;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow_out(borrow8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .diff(diff16), .borrow_out(borrow16), .busy(busy16), .done(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Runs one 8-bit operation. Operands are scrambled after acceptance to
  // show they are not re-sampled. Latency counts clock edges starting with
  // the accepting edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] ed, input logic eb, input string tag);
    int n;
    logic [7:0] prev;
    logic stable;
    prev   = diff8;
    stable = 1'b1;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = a ^ 8'h3C;
    n = 1;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    while (!done8 && n < 40) begin
      if (diff8 !== prev) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_hold"}, 32'(stable), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'd9);
    chk({tag, "_diff"}, 32'(diff8), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow8), 32'(eb));
    @(negedge clk);
    chk({tag, "_donepulse"}, 32'(done8), 32'd0);
    chk({tag, "_idle"}, 32'(busy8), 32'd0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ed, input logic eb, input string tag);
    int n;
    @(negedge clk);
    a16 = a; b16 = b; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; a16 = ~a; b16 = ~b;
    n = 1;
    while (!done16 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd17);
    chk({tag, "_diff"}, 32'(diff16), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow16), 32'(eb));
    @(negedge clk);
    chk({tag, "_donepulse"}, 32'(done16), 32'd0);
  endtask

  initial begin
    int pulses;
    int t1, t2;
    logic [7:0]  ra, rb;
    logic [15:0] sa, sb;

    rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(borrow8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    rst = 1'b0;

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'd5; b8 = 8'd3;
    @(negedge clk);
    chk("rst_prio_busy", 32'(busy8), 32'd0);
    rst = 1'b0; start8 = 1'b0;

    op8(8'd5,   8'd3,   8'h02, 1'b0, "d5m3");
    op8(8'd3,   8'd5,   8'hFE, 1'b1, "d3m5");
    op8(8'd0,   8'hFF,  8'h01, 1'b1, "d0mff");
    op8(8'hA5,  8'hA5,  8'h00, 1'b0, "deq");
    op8(8'hFF,  8'h00,  8'hFF, 1'b0, "dffm0");

    // Second start during SHIFT must be ignored.
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    pulses = 0;
    for (int e = 2; e <= 16; e++) begin
      if (e == 3) begin
        a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      if (done8) begin
        pulses++;
        chk("ign_diff", 32'(diff8), 32'd5);
      end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_idle", 32'(busy8), 32'd0);

    // Reset in the 4th SHIFT cycle abandons the operation.
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);
    op8(8'd200, 8'd100, 8'd100, 1'b0, "after_abort");

    // Back-to-back at the minimum issue interval.
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    t1 = 0; t2 = 0;
    for (int e = 1; e <= 24; e++) begin
      if (e == 10) begin
        a8 = 8'd20; b8 = 8'd50; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        if (t1 == 0) begin
          t1 = e;
          chk("b2b_diff1", 32'(diff8), 32'd30);
          chk("b2b_borrow1", 32'(borrow8), 32'd0);
        end else begin
          t2 = e;
          chk("b2b_diff2", 32'(diff8), 32'hE2);
          chk("b2b_borrow2", 32'(borrow8), 32'd1);
        end
      end else if (t1 != 0 && t2 == 0) begin
        chk("b2b_stable", 32'(diff8), 32'd30);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("b2b_first", 32'(t1), 32'd9);
    chk("b2b_gap", 32'(t2 - t1), 32'd10);

    op16(16'd0, 16'hFFFF, 16'h0001, 1'b1, "w16_0mffff");
    op16(16'h1234, 16'h1234, 16'h0000, 1'b0, "w16_eq");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8(ra, rb, ra - rb, ra < rb, "rnd8");
    end
    for (int i = 0; i < 1000; i++) begin
      sa = 16'($urandom);
      sb = 16'($urandom);
      op16(sa, sb, sa - sb, sa < sb, "rnd16");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
